// File: rtl/key_pkg.sv
// Shared types for the key debouncer: FSM state encoding and counter sizing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_e;

  // Counter must hold the larger of the debounce and long-press limits.
  function automatic int cnt_width(input int stable_cycles, input int long_cycles);
    int top;
    top = (stable_cycles > long_cycles) ? stable_cycles : long_cycles;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs before either updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer with press/release strobes and a run/pause toggle.
// Optional long-press strobe when KEY_LONGPRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int LONG_CYCLES   = 100,
  parameter bit RUN_INIT      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic run_en,
  output logic long_pulse
);

  localparam int CW = cnt_width(STABLE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  key_state_e    state, prev_state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          press_evt, release_evt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_state <= IDLE;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      prev_state <= state;
      cnt        <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= STABLE_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end else begin
`ifdef KEY_LONGPRESS_EN
          cnt_nxt = (cnt >= CW'(LONG_CYCLES)) ? cnt : cnt_inc;
`else
          cnt_nxt = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt >= STABLE_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
    endcase
  end

  // Events are seen one cycle after the qualifying transition and are
  // registered once more, giving the 2+STABLE_CYCLES press latency.
  always_comb begin
    press_evt   = (state == HELD) && (prev_state == PRESS_WAIT);
    release_evt = (state == IDLE) && (prev_state == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      run_en        <= RUN_INIT;
    end else begin
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) begin
        btn_level <= 1'b1;
        run_en    <= ~run_en;
      end else if (release_evt) begin
        btn_level <= 1'b0;
      end
    end
  end

`ifdef KEY_LONGPRESS_EN
  logic long_done;
  logic long_evt;

  // long_done keeps a release bounce back into HELD from firing twice.
  assign long_evt = (state == HELD) && (cnt == CW'(LONG_CYCLES)) && !long_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      long_pulse <= 1'b0;
      long_done  <= 1'b0;
    end else begin
      long_pulse <= long_evt;
      if (long_evt)
        long_done <= 1'b1;
      else if (state == IDLE)
        long_done <= 1'b0;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
